prbs_rx_checker: RTL

//  Receive-side checker for the LVDS loopback test. It consumes deserialized words from one

---
 rtl/prbs_rx_checker.sv | 91 +++++++++
 1 files changed

// File: rtl/prbs_rx_checker.sv
// prbs_rx_checker: locks to a PRBS7 (x^7+x^6+1) receive stream and counts received bits and bit errors.
module prbs_rx_checker #(
   parameter int DW       = 4,
   parameter int LOCK_WDS = 16,
   parameter int LOSS_WDS = 4
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          CLR,
   input  logic [DW-1:0] DIN,
   input  logic          DIN_VLD,
   output logic          LOCKED,
   output logic [57:0]   RECV_CNT,
   output logic [63:0]   ERR_CNT
);
   localparam int EW = $clog2(DW + 1);
   typedef enum logic {HUNT, LOCK} state_t;
   state_t      state, state_nxt;
   logic [6:0]  lfsr, lfsr_nxt, lfsr_w;
   logic [6:0]  hist, hist_nxt, hist_w;
   logic [7:0]  run, run_nxt, run_inc;
   logic [57:0] recv_nxt;
   logic [63:0] err_nxt;
   logic [58:0] recv_sum;
   logic [64:0] err_sum;
   logic [EW-1:0] errs;
   logic        dirty;
   // Unrolled per-bit walk: self-synchronising check against hist, free-running check against lfsr.
   always_comb begin
      hist_w = hist;
      lfsr_w = lfsr;
      dirty  = 1'b0;
      errs   = '0;
      for (int i = DW - 1; i >= 0; i--) begin
         dirty  = dirty | (DIN[i] ^ hist_w[6] ^ hist_w[5]);
         errs   = errs + EW'(DIN[i] ^ lfsr_w[6] ^ lfsr_w[5]);
         hist_w = {hist_w[5:0], DIN[i]};
         lfsr_w = {lfsr_w[5:0], lfsr_w[6] ^ lfsr_w[5]};
      end
   end
   assign run_inc  = run + 8'd1;
   assign recv_sum = {1'b0, RECV_CNT} + 59'(DW);
   assign err_sum  = {1'b0, ERR_CNT} + 65'(errs);
   always_comb begin
      state_nxt = state;
      run_nxt   = run;
      lfsr_nxt  = lfsr;
      hist_nxt  = hist;
      recv_nxt  = RECV_CNT;
      err_nxt   = ERR_CNT;
      if (DIN_VLD) begin
         hist_nxt = hist_w;
         if (state == HUNT) begin
            run_nxt = dirty ? 8'd0 : run_inc;
            if (!dirty && run_inc == 8'(LOCK_WDS)) begin
               state_nxt = LOCK;
               run_nxt   = 8'd0;
               lfsr_nxt  = hist_w;
            end
         end else begin
            lfsr_nxt = lfsr_w;
            recv_nxt = recv_sum[58] ? '1 : recv_sum[57:0];
            err_nxt  = err_sum[64] ? '1 : err_sum[63:0];
            run_nxt  = (errs != '0) ? run_inc : 8'd0;
            if (errs != '0 && run_inc == 8'(LOSS_WDS)) begin
               state_nxt = HUNT;
               run_nxt   = 8'd0;
            end
         end
      end
   end
   always_ff @(posedge CLK) begin
      if (RST || CLR) begin
         state    <= HUNT;
         LOCKED   <= 1'b0;
         RECV_CNT <= '0;
         ERR_CNT  <= '0;
         lfsr     <= 7'h7F;
         hist     <= 7'h7F;
         run      <= 8'd0;
      end else begin
         state    <= state_nxt;
         LOCKED   <= (state_nxt == LOCK);
         RECV_CNT <= recv_nxt;
         ERR_CNT  <= err_nxt;
         lfsr     <= lfsr_nxt;
         hist     <= hist_nxt;
         run      <= run_nxt;
      end
   end
endmodule
